// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types.
// Purpose : enums for the regfile write-data select and the load width/sign,
//           plus the control word and stage-register layout handed from the
//           memory stage to writeback.
// Ports   : none (package).
package rv32i_types;

  // Source of the value written to the register file.
  typedef enum logic [2:0] {
    alu_out  = 3'd0,
    br_en    = 3'd1,
    u_imm    = 3'd2,
    load     = 3'd3,
    pc_plus4 = 3'd4
  } regfilemux_sel_t;

  // Load width and signedness, encoded as the RV32I load funct3 field.
  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef struct packed {
    logic            load_regfile;
    regfilemux_sel_t regfilemux_sel;
    load_funct3_t    load_type;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    ctrl_t       ctrl;
    logic [31:0] alu;
    logic [31:0] br;
    logic [31:0] u_imm;
    logic [4:0]  rd;
    logic        valid;
  } stage_regs_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment and extension.
// Purpose : shift the 32-bit memory word right by the byte offset, then
//           sign/zero extend the byte or halfword selected by load_type.
//           Misaligned halfword/word loads use the same shift; zeros enter
//           from the top.
// Ports   : rdata     - raw 32-bit word read from memory
//           offset    - low two address bits (byte offset)
//           load_type - lb/lh/lw/lbu/lhu
//           result    - extended 32-bit load value
module load_align
  import rv32i_types::*;
(
  input  logic [31:0]  rdata,
  input  logic [1:0]   offset,
  input  load_funct3_t load_type,
  output logic [31:0]  result
);

  logic [31:0] shifted;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (default first or a default case arm), otherwise a latch is inferred.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (load_type)
      lb:      result = {{24{shifted[7]}}, shifted[7:0]};
      lbu:     result = {24'b0, shifted[7:0]};
      lh:      result = {{16{shifted[15]}}, shifted[15:0]};
      lhu:     result = {16'b0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/wb.sv
// Writeback stage (last pipeline stage).
// Purpose : captures the memory-stage output, selects the regfile write value,
//           drives the regfile write port exactly once per instruction, keeps a
//           one-deep forwarding history of the previous commit, and counts
//           retired instructions.
// Ports   : clk, reset (async, active low)
//           regs_in, dcache_rdata, stall_in        - from memory stage / hazard unit
//           load_regfile, rd, rd_data              - regfile write port
//           fwd_valid, fwd_rd, fwd_data            - previous-commit forwarding entry
//           instret, last_pc                       - retirement counter / last retired pc
module wb
  import rv32i_types::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  stage_regs_t          regs_in,
  input  logic [31:0]          dcache_rdata,
  input  logic                 stall_in,
  output logic                 load_regfile,
  output logic [4:0]           rd,
  output logic [31:0]          rd_data,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [31:0]          fwd_data,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [31:0]          last_pc
);

  stage_regs_t          wb_q;
  logic [31:0]          rdata_q;
  logic                 done_q;
  logic                 commit;
  logic [31:0]          load_data;
  logic [31:0]          mux_data;
  logic                 fwd_valid_q;
  logic [4:0]           fwd_rd_q;
  logic [31:0]          fwd_data_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic [31:0]          last_pc_q;
  logic                 unused_br;

  // Only bit 0 of the branch result is architecturally meaningful.
  assign unused_br = ^wb_q.br[31:1];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values; this is what lets a commit of the old wb_q
  // and a capture of the new instruction happen on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q    <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else if (!stall_in) begin
      wb_q    <= regs_in;
      rdata_q <= dcache_rdata;
      done_q  <= 1'b0;
    end else if (commit) begin
      // Stalled instruction has now retired; suppress repeat writes.
      done_q  <= 1'b1;
    end
  end

  assign commit = wb_q.valid & ~done_q;

  load_align u_load_align (
    .rdata     (rdata_q),
    .offset    (wb_q.alu[1:0]),
    .load_type (wb_q.ctrl.load_type),
    .result    (load_data)
  );

  always_comb begin
    mux_data = '0;
    case (wb_q.ctrl.regfilemux_sel)
      alu_out:  mux_data = wb_q.alu;
      br_en:    mux_data = {31'b0, wb_q.br[0]};
      u_imm:    mux_data = wb_q.u_imm;
      load:     mux_data = load_data;
      pc_plus4: mux_data = wb_q.pc + 32'd4;
      default:  mux_data = '0;
    endcase
  end

  // Write port is forced quiet while the stage holds a bubble.
  assign rd           = wb_q.valid ? wb_q.rd : 5'd0;
  assign rd_data      = wb_q.valid ? mux_data : 32'd0;
  assign load_regfile = commit & wb_q.ctrl.load_regfile & (wb_q.rd != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= '0;
      fwd_data_q  <= '0;
      instret_q   <= '0;
      last_pc_q   <= '0;
    end else if (commit) begin
      instret_q <= instret_q + CNT_WIDTH'(1);
      last_pc_q <= wb_q.pc;
      if (load_regfile) begin
        fwd_valid_q <= 1'b1;
        fwd_rd_q    <= wb_q.rd;
        fwd_data_q  <= mux_data;
      end else begin
        // A retired non-writer invalidates the entry but keeps rd/data.
        fwd_valid_q <= 1'b0;
      end
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_rd    = fwd_rd_q;
  assign fwd_data  = fwd_data_q;
  assign instret   = instret_q;
  assign last_pc   = last_pc_q;

endmodule

// File: tb/tb_wb.sv
// Bench for the writeback stage: issued instructions are turned into expected
// regfile writes by a reference model and queued; a negedge monitor pops and
// compares whenever the DUT asserts load_regfile, and checks the forwarding
// entry one cycle later. Counters are compared at settled checkpoints.
module tb_wb;
  import rv32i_types::*;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  stage_regs_t   regs_in;
  logic [31:0]   dcache_rdata;
  logic          stall_in;
  logic          load_regfile;
  logic [4:0]    rd;
  logic [31:0]   rd_data;
  logic          fwd_valid;
  logic [4:0]    fwd_rd;
  logic [31:0]   fwd_data;
  logic [CW-1:0] instret;
  logic [31:0]   last_pc;

  wb #(.CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .regs_in      (regs_in),
    .dcache_rdata (dcache_rdata),
    .stall_in     (stall_in),
    .load_regfile (load_regfile),
    .rd           (rd),
    .rd_data      (rd_data),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .instret      (instret),
    .last_pc      (last_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  // Architectural state of the reference model.
  logic [CW-1:0] m_instret;
  logic [31:0]   m_last_pc;
  logic          m_fwd_valid;
  logic [4:0]    m_fwd_rd;
  logic [31:0]   m_fwd_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Load value from the byte-level rules: drop 'off' low bytes, then keep a
  // byte or halfword, sign-extending by adding the upper ones when negative.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                           input load_funct3_t t);
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    w = word / (32'd1 << (8 * off));
    b = w % 256;
    h = w % 65536;
    case (t)
      lb:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      lbu:     return b;
      lh:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      lhu:     return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_value(input stage_regs_t r, input logic [31:0] d);
    case (r.ctrl.regfilemux_sel)
      alu_out:  return r.alu;
      br_en:    return r.br % 2;
      u_imm:    return r.u_imm;
      pc_plus4: return r.pc + 32'd4;
      load:     return ref_load(d, r.alu[1:0], r.ctrl.load_type);
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_instret   = '0;
    m_last_pc   = '0;
    m_fwd_valid = 1'b0;
    m_fwd_rd    = '0;
    m_fwd_data  = '0;
    exp_q.delete();
  endtask

  task automatic model_commit(input stage_regs_t r, input logic [31:0] d);
    wr_t w;
    if (!r.valid) return;
    m_instret = m_instret + 1'b1;
    m_last_pc = r.pc;
    if (r.ctrl.load_regfile && r.rd != 0) begin
      w.rd   = r.rd;
      w.data = ref_value(r, d);
      exp_q.push_back(w);
      m_fwd_valid = 1'b1;
      m_fwd_rd    = w.rd;
      m_fwd_data  = w.data;
    end else begin
      m_fwd_valid = 1'b0;
    end
  endtask

  function automatic stage_regs_t rand_instr();
    stage_regs_t r;
    r.pc                = $urandom;
    r.alu               = $urandom;
    r.br                = $urandom;
    r.u_imm             = $urandom;
    r.rd                = 5'($urandom);
    r.valid             = 1'b1;
    r.ctrl.load_regfile = ($urandom_range(0, 3) != 0);
    case ($urandom_range(0, 4))
      0:       r.ctrl.regfilemux_sel = alu_out;
      1:       r.ctrl.regfilemux_sel = br_en;
      2:       r.ctrl.regfilemux_sel = u_imm;
      3:       r.ctrl.regfilemux_sel = load;
      default: r.ctrl.regfilemux_sel = pc_plus4;
    endcase
    case ($urandom_range(0, 4))
      0:       r.ctrl.load_type = lb;
      1:       r.ctrl.load_type = lh;
      2:       r.ctrl.load_type = lw;
      3:       r.ctrl.load_type = lbu;
      default: r.ctrl.load_type = lhu;
    endcase
    return r;
  endfunction

  function automatic stage_regs_t bubble();
    stage_regs_t r;
    r       = rand_instr();
    r.valid = 1'b0;
    return r;
  endfunction

  function automatic stage_regs_t mk(input logic [31:0] pc, input regfilemux_sel_t sel,
                                     input load_funct3_t lt, input logic [31:0] alu,
                                     input logic [4:0] rdi, input logic lr);
    stage_regs_t r;
    r                     = rand_instr();
    r.pc                  = pc;
    r.ctrl.regfilemux_sel = sel;
    r.ctrl.load_type      = lt;
    r.alu                 = alu;
    r.rd                  = rdi;
    r.ctrl.load_regfile   = lr;
    return r;
  endfunction

  // Present one instruction for capture, then optionally stall for 'hold' edges.
  // Returns 1 time unit after the last edge; the captured instruction is
  // visible on the outputs when hold is 0.
  task automatic issue(input stage_regs_t r, input logic [31:0] d, input int hold);
    regs_in      = r;
    dcache_rdata = d;
    stall_in     = 1'b0;
    @(posedge clk); #1;
    model_commit(r, d);
    regs_in      = bubble();
    dcache_rdata = $urandom;
    stall_in     = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    stall_in = 1'b0;
  endtask

  task automatic checkpoint(input string tag);
    regs_in  = bubble();
    stall_in = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check({tag, ".instret"}, instret, m_instret);
    check({tag, ".last_pc"}, last_pc, m_last_pc);
    check({tag, ".fwd_valid"}, fwd_valid, m_fwd_valid);
    check({tag, ".fwd_rd"}, fwd_rd, m_fwd_rd);
    check({tag, ".fwd_data"}, fwd_data, m_fwd_data);
    check({tag, ".idle_we"}, load_regfile, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".load_regfile"}, load_regfile, 0);
    check({tag, ".rd"}, rd, 0);
    check({tag, ".rd_data"}, rd_data, 0);
    check({tag, ".fwd_valid"}, fwd_valid, 0);
    check({tag, ".fwd_rd"}, fwd_rd, 0);
    check({tag, ".fwd_data"}, fwd_data, 0);
    check({tag, ".instret"}, instret, 0);
    check({tag, ".last_pc"}, last_pc, 0);
  endtask

  // Monitor: pops an expected write whenever the DUT writes, and checks the
  // forwarding entry on the following sample.
  logic fwd_pending = 1'b0;
  wr_t  last_w;

  always @(negedge clk) begin
    if (!reset) begin
      fwd_pending = 1'b0;
    end else begin
      if (fwd_pending) begin
        check("mon.fwd_valid", fwd_valid, 1);
        check("mon.fwd_rd", fwd_rd, last_w.rd);
        check("mon.fwd_data", fwd_data, last_w.data);
        fwd_pending = 1'b0;
      end
      if (load_regfile) begin
        if (exp_q.size() == 0) begin
          check("mon.unexpected_write", load_regfile, 0);
        end else begin
          last_w = exp_q.pop_front();
          check("mon.rd", rd, last_w.rd);
          check("mon.rd_data", rd_data, last_w.data);
          fwd_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed load table: dcache word 0x80FF_7F01.
  load_funct3_t ld_type[5] = '{lb, lbu, lh, lhu, lw};
  logic [1:0]   ld_off [5] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
  logic [31:0]  ld_exp [5] = '{32'h0000_007F, 32'h0000_007F, 32'hFFFF_80FF,
                               32'h0000_80FF, 32'h80FF_7F01};

  initial begin
    stage_regs_t r;
    logic [CW-1:0] base;

    reset        = 1'b0;
    regs_in      = bubble();
    dcache_rdata = '0;
    stall_in     = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // ALU writeback.
    r = mk(32'h0000_0100, alu_out, lw, 32'h1234_5678, 5'd5, 1'b1);
    issue(r, 32'h0, 0);
    check("alu.load_regfile", load_regfile, 1);
    check("alu.rd", rd, 5);
    check("alu.rd_data", rd_data, 32'h1234_5678);
    checkpoint("alu");
    check("alu.instret_is_1", instret, 1);
    check("alu.fwd_data_const", fwd_data, 32'h1234_5678);

    // Load extraction.
    for (int i = 0; i < 5; i++) begin
      r = mk(32'h0000_0200 + 32'(4 * i), load, ld_type[i], {30'h0000_1000, ld_off[i]}, 5'd7, 1'b1);
      issue(r, 32'h80FF_7F01, 0);
      check($sformatf("load%0d.rd_data", i), rd_data, ld_exp[i]);
    end
    checkpoint("loads");

    // Stall: write only in the first stalled cycle, one retirement.
    base         = m_instret;
    r            = mk(32'h0000_0300, load, lw, 32'h0000_0040, 5'd3, 1'b1);
    regs_in      = r;
    dcache_rdata = 32'hCAFE_F00D;
    stall_in     = 1'b0;
    @(posedge clk); #1;
    model_commit(r, 32'hCAFE_F00D);
    regs_in  = bubble();
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall.we_cycle%0d", i), load_regfile, (i == 0));
      @(posedge clk); #1;
    end
    stall_in = 1'b0;
    checkpoint("stall");
    check("stall.instret_plus1", instret, base + 1'b1);

    // rd=0 write request and a store.
    issue(mk(32'h0000_0400, alu_out, lw, 32'hDEAD_BEEF, 5'd0, 1'b1), 32'h0, 0);
    checkpoint("rd0");
    issue(mk(32'h0000_2000, alu_out, lw, 32'h0000_0010, 5'd9, 1'b0), 32'h0, 0);
    checkpoint("store");
    check("store.last_pc_const", last_pc, 32'h0000_2000);

    // Bubbles.
    for (int i = 0; i < 3; i++) issue(bubble(), $urandom, 0);
    checkpoint("bubbles");

    // Counter wrap, back-to-back random traffic.
    while (m_instret != {CW{1'b1}}) issue(rand_instr(), $urandom, 0);
    checkpoint("prewrap");
    issue(rand_instr(), $urandom, 0);
    checkpoint("wrap");
    check("wrap.instret_zero", instret, 0);

    // Random mix of instructions, bubbles and stalls.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) issue(bubble(), $urandom, $urandom_range(0, 2));
      else                           issue(rand_instr(), $urandom, $urandom_range(0, 2));
    end
    checkpoint("random");

    // Asynchronous reset in the middle of a stall with a pending write.
    r            = mk(32'h0000_0500, u_imm, lw, 32'h0, 5'd12, 1'b1);
    regs_in      = r;
    dcache_rdata = $urandom;
    stall_in     = 1'b0;
    @(posedge clk); #1;
    model_commit(r, dcache_rdata);
    regs_in  = bubble();
    stall_in = 1'b1;
    check("arst.pending_write", load_regfile, 1);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_all_zero("arst.immediate");
    @(posedge clk); #1;
    check_all_zero("arst.held");
    @(negedge clk);
    reset    = 1'b1;
    stall_in = 1'b0;
    issue(mk(32'h0000_0600, pc_plus4, lw, 32'h0, 5'd14, 1'b1), 32'h0, 0);
    checkpoint("post_reset");
    check("post_reset.instret_is_1", instret, 1);

    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
